// File: rtl/rx_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised receive FIFO.
package rx_fifo_pkg;

  localparam int RX_FIFO_DEFAULT_WIDTH = 8;
  localparam int RX_FIFO_DEFAULT_DEPTH = 8;

  // Occupancy ranges over 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int rx_fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit rx_fifo_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rx_fifo_ctrl.sv
// Pointer/count/flag control for rx_fifo_param. Sticky overflow/underflow
// registers exist only when RX_FIFO_ERR_EN is defined; otherwise tied to 0.
module rx_fifo_ctrl
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH     = RX_FIFO_DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_i,
  input  logic                             w_enable_i,
  input  logic                             r_enable_i,
  output logic                             wa_o,
  output logic [$clog2(DEPTH)-1:0]         wptr_o,
  output logic [$clog2(DEPTH)-1:0]         rptr_o,
  output logic [rx_fifo_cnt_w(DEPTH)-1:0]  count_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic                             almost_empty_o,
  output logic                             almost_full_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = rx_fifo_cnt_w(DEPTH);

  if (!rx_fifo_is_pow2(DEPTH)) begin : g_depth_chk
    $error("rx_fifo_ctrl: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wa, ra;

  assign empty_o        = (cnt_q == '0);
  assign full_o         = (cnt_q == CW'(DEPTH));
  assign almost_empty_o = (cnt_q <= CW'(AE_THRESH));
  assign almost_full_o  = (cnt_q >= CW'(AF_THRESH));

  // A pop while full frees the slot this same cycle, so the push goes through.
  assign wa = w_enable_i & (~full_o | r_enable_i) & ~clear_i;
  assign ra = r_enable_i & ~empty_o & ~clear_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wa) wptr_d = wptr_q + 1'b1;
      if (ra) rptr_d = rptr_q + 1'b1;
      case ({wa, ra})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wa_o    = wa;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = cnt_q;

`ifdef RX_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (w_enable_i & full_o & ~r_enable_i);
    unf_d = unf_q | (r_enable_i & empty_o);
    if (clear_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: rtl/rx_fifo_param.sv
// Parametrised first-word-fall-through receive FIFO. Define RX_FIFO_ERR_EN to
// build the sticky overflow/underflow error flags.
module rx_fifo_param
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RX_FIFO_DEFAULT_WIDTH,
  parameter int DEPTH      = RX_FIFO_DEFAULT_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            w_enable,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic                            r_enable,
  output logic [DATA_WIDTH-1:0]           r_data,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [rx_fifo_cnt_w(DEPTH)-1:0] count,
  output logic                            overflow,
  output logic                            underflow
);
  logic [$clog2(DEPTH)-1:0] wptr, rptr;
  logic                     wa;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  rx_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (clear),
    .w_enable_i     (w_enable),
    .r_enable_i     (r_enable),
    .wa_o           (wa),
    .wptr_o         (wptr),
    .rptr_o         (rptr),
    .count_o        (count),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (almost_empty),
    .almost_full_o  (almost_full),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  // Storage carries no reset; the zeroed count makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wa) mem_q[wptr] <= w_data;
  end

  assign r_data = empty ? '0 : mem_q[rptr];

endmodule
